// File: rtl/viterbi_link_if.sv
// Handshake/bus bundle between the link sequencer and encoder, channel, decoder.
// slave: sequencer side; master: environment side (payload source, decoder).
interface viterbi_link_if #(
  parameter int CNT_W = 16
) ();
  logic             start_i;
  logic             data_i;
  logic             data_ready_o;
  logic             enc_enable_o;
  logic             enc_data_o;
  logic             inj_en_i;
  logic [1:0]       err_mode_i;
  logic [1:0]       err_inj_o;
  logic             dec_data_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] chan_err_o;
  logic [CNT_W-1:0] bit_err_o;

  modport slave (
    input  start_i, data_i, inj_en_i, err_mode_i, dec_data_i,
    output data_ready_o, enc_enable_o, enc_data_o, err_inj_o,
    output busy_o, done_o, chan_err_o, bit_err_o
  );

  modport master (
    output start_i, data_i, inj_en_i, err_mode_i, dec_data_i,
    input  data_ready_o, enc_enable_o, enc_data_o, err_inj_o,
    input  busy_o, done_o, chan_err_o, bit_err_o
  );
endinterface

// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer for encoder -> channel -> Viterbi decoder: streams payload
// and tail bits, schedules burst error injection, counts channel/decoded errors.
module viterbi_link_ctrl #(
  parameter int FRAME_LEN = 256,
  parameter int TAIL_LEN  = 8,
  parameter int DEC_LAT   = 16,
  parameter int BURST_PER = 32,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  viterbi_link_if.slave lnk
);

  typedef enum logic [2:0] {IDLE, SEND, TAIL, DRAIN, DONE} state_t;

  localparam int M1   = (FRAME_LEN > TAIL_LEN) ? FRAME_LEN : TAIL_LEN;
  localparam int MAXC = (M1 > DEC_LAT) ? M1 : DEC_LAT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (BURST_PER > 1) ? $clog2(BURST_PER) : 1;

  localparam logic [CW-1:0] SEND_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] TAIL_LAST  = CW'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DEC_LAT - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            ready, enc_en, enc_bit, done;

  logic            inj_en_q;
  logic [1:0]      mode_q;
  logic [PW-1:0]   phase;
  logic [1:0]      err_inj;
  logic [CNT_W-1:0] chan_err, bit_err;
  logic [1:0]      dl [DEC_LAT];

  logic            start_go;
  logic            in_burst;
  logic [1:0]      pop;
  logic [CNT_W:0]  chan_sum;
  logic            chk_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    ready    = 1'b0;
    enc_en   = 1'b0;
    enc_bit  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (lnk.start_i) state_nx = SEND;
      end
      SEND: begin
        ready   = 1'b1;
        enc_en  = 1'b1;
        enc_bit = lnk.data_i;
        if (cnt == SEND_LAST) begin
          cnt_nx   = '0;
          state_nx = (TAIL_LEN == 0) ? DRAIN : TAIL;
        end
      end
      TAIL: begin
        enc_en = 1'b1;
        if (cnt == TAIL_LAST) begin
          cnt_nx   = '0;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign start_go = (state == IDLE) && lnk.start_i;
  // Widened compare so BURST_LEN == BURST_PER (always corrupt) fits.
  assign in_burst = {1'b0, phase} < (PW + 1)'(BURST_LEN);
  assign pop      = {1'b0, err_inj[0]} + {1'b0, err_inj[1]};
  assign chan_sum = {1'b0, chan_err} + (CNT_W + 1)'(pop);
  assign chk_hit  = dl[DEC_LAT-1][1] &&
                    (lnk.dec_data_i != dl[DEC_LAT-1][0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_en_q <= 1'b0;
      mode_q   <= 2'b00;
      phase    <= '0;
      err_inj  <= 2'b00;
      chan_err <= '0;
      bit_err  <= '0;
      for (int i = 0; i < DEC_LAT; i++) dl[i] <= 2'b00;
    end else begin
      // Mask is registered so it lines up with the registered encoder symbol.
      err_inj <= (enc_en && inj_en_q && in_burst) ? mode_q : 2'b00;
      if (start_go) begin
        inj_en_q <= lnk.inj_en_i;
        mode_q   <= lnk.err_mode_i;
        phase    <= '0;
        chan_err <= '0;
        bit_err  <= '0;
      end else begin
        chan_err <= chan_sum[CNT_W] ? '1 : chan_sum[CNT_W-1:0];
        if (chk_hit && !(&bit_err)) bit_err <= bit_err + 1'b1;
        if (enc_en && (BURST_PER > 1)) phase <= phase + 1'b1;
      end
      // Tag marks payload bits; tail and idle slots are never compared.
      dl[0] <= {state == SEND, enc_bit};
      for (int i = 1; i < DEC_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign lnk.data_ready_o = ready;
  assign lnk.enc_enable_o = enc_en;
  assign lnk.enc_data_o   = enc_bit;
  assign lnk.err_inj_o    = err_inj;
  assign lnk.busy_o       = (state != IDLE);
  assign lnk.done_o       = done;
  assign lnk.chan_err_o   = chan_err;
  assign lnk.bit_err_o    = bit_err;

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Scoreboard bench for viterbi_link_ctrl: default-parameter frames plus a
// small saturating instance (CNT_W=4, no tail, always-on burst).
module tb_viterbi_link_ctrl;

  localparam int FL = 256;
  localparam int TL = 8;
  localparam int DL = 16;
  localparam int BP = 32;
  localparam int BL = 4;
  localparam int NSYM = FL + TL;
  localparam int DONE_CYC = 1 + FL + TL + DL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  viterbi_link_if #(.CNT_W(16)) lnk ();
  viterbi_link_if #(.CNT_W(4))  lnk2 ();

  viterbi_link_ctrl #(
    .FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(DL),
    .BURST_PER(BP), .BURST_LEN(BL), .CNT_W(16)
  ) dut (.clk(clk), .rst(rst), .lnk(lnk));

  viterbi_link_ctrl #(
    .FRAME_LEN(16), .TAIL_LEN(0), .DEC_LAT(2),
    .BURST_PER(4), .BURST_LEN(4), .CNT_W(4)
  ) dut2 (.clk(clk), .rst(rst), .lnk(lnk2));

  typedef struct {
    int inj;
    int mode;
    int chan;
    int bits;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Payload source
  logic [15:0] lfsr;
  always @(posedge clk or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else if (lnk.data_ready_o)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign lnk.data_i = lfsr[0];

  // Ideal decoder model with optional corruption of bits 5 and 258 (tail)
  logic [DL-1:0] dline;
  int k;
  bit flip_en = 1'b0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      dline <= '0;
      k <= 0;
    end else begin
      if (lnk.enc_enable_o) k <= k + 1;
      else if (!lnk.busy_o) k <= 0;
      dline <= {dline[DL-2:0], lnk.enc_data_o ^
               (flip_en && lnk.enc_enable_o && (k == 5 || k == 258))};
    end
  assign lnk.dec_data_i = dline[DL-1];

  assign lnk2.data_i = 1'b0;
  assign lnk2.dec_data_i = 1'b0;
  assign lnk2.inj_en_i = 1'b1;
  assign lnk2.err_mode_i = 2'b11;

  // Monitor: main instance
  int cyc, nrdy, nen, nbadinj, em;
  bit pb = 1'b0;
  bit have = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      pb = 1'b0;
    end else begin
      if (lnk.busy_o && !pb) begin
        cyc = 0; nrdy = 0; nen = 0; nbadinj = 0;
        have = (q.size() > 0);
        if (have) cur = q[0];
      end
      if (lnk.busy_o) begin
        cyc++;
        nrdy += int'(lnk.data_ready_o);
        nen += int'(lnk.enc_enable_o);
        if (have) begin
          em = (cur.inj != 0 && cyc >= 2 && cyc <= NSYM + 1 &&
                ((cyc - 2) % BP) < BL) ? cur.mode : 0;
          if (int'(lnk.err_inj_o) != em) nbadinj++;
        end
      end
      if (lnk.done_o) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          cur = q.pop_front();
          chk("done_cycle", cyc, DONE_CYC);
          chk("chan_err", int'(lnk.chan_err_o), cur.chan);
          chk("bit_err", int'(lnk.bit_err_o), cur.bits);
          chk("ready_pulses", nrdy, FL);
          chk("enable_cycles", nen, NSYM);
          chk("inj_pattern_errs", nbadinj, 0);
        end
      end
      pb = lnk.busy_o;
    end
  end

  // Monitor: saturating instance
  int cyc2;
  bit pb2 = 1'b0;
  exp_t cur2;
  always @(negedge clk) begin
    if (rst) begin
      pb2 = 1'b0;
    end else begin
      if (lnk2.busy_o && !pb2) cyc2 = 0;
      if (lnk2.busy_o) cyc2++;
      if (lnk2.busy_o && cyc2 == 12)
        chk("sat_mid", int'(lnk2.chan_err_o), 15);
      if (lnk2.done_o) begin
        if (q2.size() == 0) chk("unexpected_done2", 1, 0);
        else begin
          cur2 = q2.pop_front();
          chk("done_cycle2", cyc2, 19);
          chk("chan_err_sat", int'(lnk2.chan_err_o), cur2.chan);
          chk("bit_err2", int'(lnk2.bit_err_o), cur2.bits);
        end
      end
      pb2 = lnk2.busy_o;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(lnk.busy_o), 0);
    chk({tag, "_done"}, int'(lnk.done_o), 0);
    chk({tag, "_ready"}, int'(lnk.data_ready_o), 0);
    chk({tag, "_enc_en"}, int'(lnk.enc_enable_o), 0);
    chk({tag, "_enc_data"}, int'(lnk.enc_data_o), 0);
    chk({tag, "_err_inj"}, int'(lnk.err_inj_o), 0);
    chk({tag, "_chan_err"}, int'(lnk.chan_err_o), 0);
    chk({tag, "_bit_err"}, int'(lnk.bit_err_o), 0);
  endtask

  task automatic start_frame(input bit inj, input int mode, input bit flip,
                             input int chan, input int bits, input bit push);
    flip_en = flip;
    lnk.inj_en_i = inj;
    lnk.err_mode_i = 2'(mode);
    if (push) q.push_back('{int'(inj), mode, chan, bits});
    @(negedge clk);
    lnk.start_i = 1'b1;
    @(negedge clk);
    lnk.start_i = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while ((q.size() != 0 || lnk.busy_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      chk("frame_timeout", 1, 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    lnk.start_i = 1'b0;
    lnk.inj_en_i = 1'b0;
    lnk.err_mode_i = 2'b00;
    lnk2.start_i = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    start_frame(1'b0, 0, 1'b0, 0, 0, 1'b1);
    wait_frame();
    start_frame(1'b1, 2, 1'b0, 36, 0, 1'b1);
    wait_frame();
    start_frame(1'b1, 3, 1'b0, 72, 0, 1'b1);
    wait_frame();
    start_frame(1'b0, 0, 1'b1, 0, 1, 1'b1);
    wait_frame();

    // Start requests during SEND and DONE must be ignored
    start_frame(1'b0, 0, 1'b0, 0, 0, 1'b1);
    repeat (50) @(negedge clk);
    lnk.start_i = 1'b1;
    @(negedge clk);
    lnk.start_i = 1'b0;
    n = 0;
    while (!lnk.done_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(lnk.done_o), 1);
    lnk.start_i = 1'b1;
    @(negedge clk);
    lnk.start_i = 1'b0;
    chk("start_in_done_ignored", int'(lnk.busy_o), 0);
    wait_frame();

    // Abort mid-payload with injection running
    start_frame(1'b1, 3, 1'b0, 0, 0, 1'b0);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start_frame(1'b1, 1, 1'b0, 36, 0, 1'b1);
    wait_frame();

    // Saturation on the small instance
    q2.push_back('{1, 3, 15, 0});
    @(negedge clk);
    lnk2.start_i = 1'b1;
    @(negedge clk);
    lnk2.start_i = 1'b0;
    n = 0;
    while ((q2.size() != 0 || lnk2.busy_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("frame_timeout2", 1, 0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
